// File: rtl/serial_addsub_word.sv
// rtl/serial_addsub_word.sv - digit-serial two's-complement adder/subtractor with word framing
module serial_addsub_word #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             sub,
    input  logic [DIGIT-1:0] a_in,
    input  logic [DIGIT-1:0] b_in,
    output logic [DIGIT-1:0] s_out,
    output logic             s_valid,
    output logic [WIDTH-1:0] sum_word,
    output logic             busy,
    output logic             done,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic [DIGIT-1:0] s_out_q, s_out_d;
    logic             s_valid_q, s_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // In IDLE the start cycle already computes digit 0, so mode and carry-in
    // come straight from the sub input rather than from the registers.
    logic             mode;
    logic             cin;
    logic [DIGIT-1:0] b_eff;
    logic [DIGIT:0]   add_full;
    logic [DIGIT-1:0] s_dig;
    logic [WIDTH-1:0] sum_shift;
    logic             step;
    logic             last;

    assign mode     = (state_q == S_IDLE) ? sub : sub_q;
    assign cin      = (state_q == S_IDLE) ? sub : carry_q;
    assign b_eff    = mode ? ~b_in : b_in;
    assign add_full = {1'b0, a_in} + {1'b0, b_eff} + {{DIGIT{1'b0}}, cin};
    assign s_dig    = add_full[DIGIT-1:0];

    // New digits enter at the MSB end so digit 0 lands at the LSB after NDIG shifts.
    generate
        if (DIGIT == WIDTH) begin : g_whole
            assign sum_shift = s_dig;
        end else begin : g_shift
            assign sum_shift = {s_dig, sum_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            sub_q     <= 1'b0;
            s_out_q   <= '0;
            s_valid_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            sub_q     <= sub_d;
            s_out_q   <= s_out_d;
            s_valid_q <= s_valid_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next-state logic and digit processing; flags only update on the last digit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        sub_d     = sub_q;
        s_out_d   = s_out_q;
        s_valid_d = 1'b0;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        step      = 1'b0;
        last      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en && start) begin
                    step    = 1'b1;
                    sub_d   = sub;
                    cnt_d   = CW'(1);
                    last    = (NDIG == 1);
                    state_d = (NDIG == 1) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (en) begin
                    step  = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                    last  = (cnt_q == LAST_DIG);
                    if (cnt_q == LAST_DIG) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (step) begin
            s_out_d   = s_dig;
            s_valid_d = 1'b1;
            carry_d   = add_full[DIGIT];
            sum_d     = sum_shift;
            if (last) begin
                cout_d = add_full[DIGIT];
                ovf_d  = (a_in[DIGIT-1] == b_eff[DIGIT-1]) && (s_dig[DIGIT-1] != a_in[DIGIT-1]);
            end
        end
    end

    assign s_out     = s_out_q;
    assign s_valid   = s_valid_q;
    assign sum_word  = sum_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/serial_addsub_word.md
Name: serial_addsub_word

Overview:
Parametrised digit-serial adder/subtractor. It processes one WIDTH-bit two's-complement word LSB-first, DIGIT bits per enabled cycle. A single carry register links the digits. The block replaces the fixed 1-bit serial adder in the datapath and adds word framing, subtract mode, a start/done handshake, a parallel result word and carry/overflow flags.

Parameters:
WIDTH, 8, word length in bits; must be a multiple of DIGIT.
DIGIT, 1, bits consumed and produced per enabled cycle; 1 <= DIGIT <= WIDTH.
NDIG (localparam), WIDTH/DIGIT, number of digits per word.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-low (0 = reset)
en  in  1  clock enable; 0 = stall, all state held
start  in  1  starts a word; honoured only in IDLE with en=1
sub  in  1  mode, sampled with start: 0 = A+B, 1 = A-B
a_in  in  DIGIT  current digit of A, LSB-first
b_in  in  DIGIT  current digit of B, LSB-first
s_out  out  DIGIT  registered sum digit
s_valid  out  1  s_out holds a new digit this cycle
sum_word  out  WIDTH  assembled result; valid when done=1
busy  out  1  high in RUN
done  out  1  one-cycle pulse; word complete
carry_out  out  1  final carry (sub: 1 = no borrow); valid with done
overflow  out  1  signed overflow; valid with done

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; carry, digit counter, mode reg, s_out, sum_word, carry_out and overflow all 0.
  - s_valid, busy and done are 0.
- FSM states: IDLE, RUN, DONE. Encoding is free.
- Digit operation (whenever a digit is processed):
  - b_eff = sub_r ? ~b_in : b_in.
  - {c_next, s} = a_in + b_eff + carry, with DIGIT+1 bit arithmetic.
  - At the next clock edge: s_out <= s, s_valid=1, carry <= c_next, and s is shifted into sum_word from the MSB end (sum_word <= {s, sum_word[WIDTH-1:DIGIT]}). After NDIG digits, digit 0 sits at the LSB.
- IDLE:
  - If en & start: latch sub_r <= sub and initialise carry-in = sub (+1 for two's complement).
  - Digit 0 is processed in that same cycle using this carry-in; counter <= 1.
  - Next state is DONE if NDIG==1, else RUN.
  - start with en=0 is ignored.
- RUN:
  - If en=1: process digit[counter] and increment the counter. When the last digit (counter==NDIG-1) is processed, next state = DONE.
  - If en=0: hold counter, carry, s_out and sum_word; s_valid=0.
  - start is ignored.
- DONE:
  - Lasts exactly one cycle, independent of en.
  - done=1; s_valid=1 for the last digit in this same cycle.
  - sum_word, carry_out and overflow are final.
  - Next state is IDLE. start is ignored. carry_out and overflow hold until the next word's DONE or until reset.
- Flag computation, on the last digit:
  - carry_out = c_next.
  - overflow = (a_msb == b_eff_msb) && (s_msb != a_msb).
- s_valid is high exactly NDIG times per word, and only in cycles following an enabled digit.
- Latency: for an unstalled word, start cycle T gives done at T+NDIG. Each en=0 cycle in RUN adds one cycle.
- Back-to-back operation: the earliest next start is the cycle after DONE (IDLE). Throughput is 1 word per NDIG+1 cycles.
- Reset mid-operation aborts the word immediately. No done pulse is issued; the bench waits for IDLE before restarting.

Test Plan:
1. WIDTH=8, DIGIT=1, sub=0, A=0x5A, B=0x3C, en=1 -> done at T+8; sum_word=0x96, carry_out=0, overflow=1; s_out bit stream 0,1,1,0,1,0,0,1.
2. WIDTH=8, DIGIT=1, sub=1, A=0x10, B=0x20 -> sum_word=0xF0, carry_out=0 (borrow), overflow=0. Then A=0x80, B=0x01 -> sum_word=0x7F, carry_out=1, overflow=1.
3. WIDTH=8, DIGIT=4, sub=0, A=0xFF, B=0x01 -> s_valid twice (digits 0x0, 0x0); done at T+2; sum_word=0x00, carry_out=1, overflow=0.
4. Stall: WIDTH=8, DIGIT=1, case 1 with en=0 for 3 cycles after digit 3 -> s_valid=0 and s_out/counter held during the stall; done at T+11; identical results to case 1.
5. Protocol: start held high through RUN and DONE -> single word only; the next word starts in the IDLE cycle after DONE. start with en=0 in IDLE -> no busy, no s_valid.
6. Reset: rst=0 asserted asynchronously mid-word at digit 4 -> outputs clear immediately with no done; after release, a fresh case 1 gives 0x96.
